// File: rtl/sdram_arbiter2_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter2_if
// Avalon-MM style pipelined-read bus used on each side of sdram_arbiter2.
//   address        word address, master -> slave
//   byteenable_n   active-low byte lanes, master -> slave
//   writedata      write data, master -> slave
//   read_n         read request (active low), master -> slave
//   write_n        write request (active low), master -> slave
//   readdata       read data, slave -> master
//   readdatavalid  read data qualifier, slave -> master
//   waitrequest    stall, slave -> master
// Modports: master (drives the request side), slave (drives the response side).
// -----------------------------------------------------------------------------
interface sdram_arbiter2_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable_n;
    logic [DATA_W-1:0] writedata;
    logic              read_n;
    logic              write_n;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, byteenable_n, writedata, read_n, write_n,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable_n, writedata, read_n, write_n,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sdram_arbiter2.sv
// -----------------------------------------------------------------------------
// sdram_arbiter2
// Shares the single SDRAM controller slave port between master m0 (video/DMA)
// and master m1 (CPU). Grants are round-robin with a burst cap that only bites
// while the other master is waiting. Accepted reads push the issuing master's
// tag into a small FIFO so each returning readdatavalid beat is steered back to
// the right master with no added latency.
// Ports:
//   clk_clk           system clock
//   reset_reset_n     asynchronous active-low reset
//   m0, m1            requesting masters (slave modport of sdram_arbiter2_if)
//   sdram             controller port (master modport of sdram_arbiter2_if)
//   sdram_chipselect  transfer qualifier towards the controller
//   err_orphan        sticky: readdatavalid seen with no read outstanding
// -----------------------------------------------------------------------------
module sdram_arbiter2 #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2,
    parameter int MAX_BURST   = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    sdram_arbiter2_if.slave  m0,
    sdram_arbiter2_if.slave  m1,
    sdram_arbiter2_if.master sdram,
    output logic             sdram_chipselect,
    output logic             err_orphan
);

    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_PENDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PENDING);
    localparam logic [BC_W-1:0]  BC_MAX   = BC_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_owner;
    logic [BC_W-1:0]   burst_cnt;
    logic [BC_W-1:0]   burst_inc;

    logic [MAX_PENDING-1:0] tag_mem;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic req0, req1;
    logic own0, own1;
    logic own_req, own_read;
    logic fifo_full, fifo_empty;
    logic read_block;
    logic accepted, push, pop, leave;
    logic head_tag;

    logic [ADDR_W-1:0] fwd_address;
    logic [BE_W-1:0]   fwd_byteenable_n;
    logic [DATA_W-1:0] fwd_writedata;
    logic              fwd_read_n;
    logic              fwd_write_n;
    logic              m0_wait, m1_wait;
    logic              m0_rdv, m1_rdv;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Request / ownership decode shared by the FSM and the datapath mux
    assign req0       = ~m0.read_n | ~m0.write_n;
    assign req1       = ~m1.read_n | ~m1.write_n;
    assign own0       = (state == OWN0);
    assign own1       = (state == OWN1);
    assign own_req    = (own0 & req0) | (own1 & req1);
    assign own_read   = (own0 & ~m0.read_n) | (own1 & ~m1.read_n);
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    // A full FIFO stalls reads even if a beat pops this cycle; this keeps the
    // stall off the readdatavalid timing path.
    assign read_block = own_read & fifo_full;
    assign accepted   = sdram_chipselect & ~sdram.waitrequest;
    assign push       = accepted & own_read;
    assign pop        = sdram.readdatavalid & ~fifo_empty;
    assign head_tag   = tag_mem[rd_ptr];
    assign burst_inc  = (accepted && burst_cnt != BC_MAX) ? burst_cnt + 1'b1 : burst_cnt;
    assign leave      = (state != IDLE) && (state_nxt != state);

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: the burst cap compares the count including this cycle's
    // transfer so the owner gets exactly MAX_BURST transfers.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0 || (burst_inc == BC_MAX && req1))
                    state_nxt = req1 ? OWN1 : IDLE;
            end
            OWN1: begin
                if (!req1 || (burst_inc == BC_MAX && req0))
                    state_nxt = req0 ? OWN0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: request mux from the owner and tag-steered return path
    always_comb begin
        fwd_address      = own1 ? m1.address      : m0.address;
        fwd_byteenable_n = own1 ? m1.byteenable_n : m0.byteenable_n;
        fwd_writedata    = own1 ? m1.writedata    : m0.writedata;
        fwd_read_n       = 1'b1;
        fwd_write_n      = 1'b1;
        m0_wait          = 1'b1;
        m1_wait          = 1'b1;
        if (own0) begin
            fwd_read_n  = m0.read_n;
            // read wins when both strobes are low
            fwd_write_n = m0.write_n | ~m0.read_n;
            m0_wait     = sdram.waitrequest | read_block | ~req0;
        end else if (own1) begin
            fwd_read_n  = m1.read_n;
            fwd_write_n = m1.write_n | ~m1.read_n;
            m1_wait     = sdram.waitrequest | read_block | ~req1;
        end
        sdram_chipselect = own_req & ~read_block;
        m0_rdv           = pop & ~head_tag;
        m1_rdv           = pop & head_tag;
    end

    assign sdram.address      = fwd_address;
    assign sdram.byteenable_n = fwd_byteenable_n;
    assign sdram.writedata    = fwd_writedata;
    assign sdram.read_n       = fwd_read_n;
    assign sdram.write_n      = fwd_write_n;

    assign m0.waitrequest   = m0_wait;
    assign m1.waitrequest   = m1_wait;
    assign m0.readdata      = sdram.readdata;
    assign m1.readdata      = sdram.readdata;
    assign m0.readdatavalid = m0_rdv;
    assign m1.readdatavalid = m1_rdv;

    // Grant bookkeeping
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else if (leave) begin
            last_owner <= own1;
            burst_cnt  <= '0;
        end else begin
            burst_cnt  <= burst_inc;
        end
    end

    // Read-tag FIFO control
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (sdram.readdatavalid && fifo_empty)
                err_orphan <= 1'b1;
        end
    end

    // Tag storage is only read behind a non-zero count, so it needs no reset
    always_ff @(posedge clk_clk) begin
        if (push)
            tag_mem[wr_ptr] <= own1;
    end

endmodule

// File: doc/sdram_arbiter2.md
Name: sdram_arbiter2

Overview:
Two-master arbiter that shares the single Avalon-MM slave port of the SDRAM controller between a high-bandwidth master m0 (video/DMA) and a CPU-side master m1. The block sits between both masters and the controller's sdram_* port. It grants the port round-robin with a burst cap. It tracks outstanding pipelined reads in a tag FIFO so each sdram_readdatavalid beat is returned to the master that issued the read.

Parameters:
ADDR_W, 22, word address width
DATA_W, 16, data width
BE_W, 2, byte-enable width (active-low lanes)
MAX_BURST, 8, maximum consecutive accepted transactions per grant while the other master is waiting
MAX_PENDING, 4, read-tag FIFO depth, i.e. the maximum number of outstanding reads

Ports:
clk_clk  in  1  single system clock
reset_reset_n  in  1  asynchronous active-low reset
mN_address  in  ADDR_W  master N address (N = 0,1; the same set of ports exists for each master)
mN_byteenable_n  in  BE_W  master N byte enables, active low
mN_writedata  in  DATA_W  master N write data
mN_read_n  in  1  master N read request, active low
mN_write_n  in  1  master N write request, active low
mN_readdata  out  DATA_W  read data returned to master N
mN_readdatavalid  out  1  read data valid for master N
mN_waitrequest  out  1  stall to master N
sdram_address  out  ADDR_W  to controller
sdram_byteenable_n  out  BE_W  to controller
sdram_chipselect  out  1  to controller
sdram_writedata  out  DATA_W  to controller
sdram_read_n  out  1  to controller
sdram_write_n  out  1  to controller
sdram_readdata  in  DATA_W  from controller
sdram_readdatavalid  in  1  from controller
sdram_waitrequest  in  1  from controller
err_orphan  out  1  sticky flag: readdatavalid received while the tag FIFO was empty

Behaviour:
- Reset: asynchronous, active-low; clk_clk and reset_reset_n are the only clock and reset. Reset values: state IDLE, last_owner=1, burst count 0, FIFO empty, err_orphan 0. Outputs at reset: sdram_chipselect 0, sdram_read_n 1, sdram_write_n 1, both mN_waitrequest 1, both mN_readdatavalid 0. Reads in flight when reset asserts are discarded; the controller is reset from the same reset_reset_n.
- Request definition: reqN = ~mN_read_n | ~mN_write_n. If both read_n and write_n are low, the transfer is treated as a read and the write is suppressed.
- States: IDLE, OWN0, OWN1. All are registered; a grant takes effect on the cycle after the decision.
- IDLE:
  - If exactly one master requests, go to its OWN state.
  - If both request, go to the master that is not last_owner.
  - Nothing is forwarded in IDLE. Arbitration latency is therefore 1 cycle from request to the first forwarded cycle.
- OWNx forwarding (combinational mux from the owner):
  - Forwarded: address, byteenable_n, writedata, read_n, write_n.
  - sdram_chipselect = reqx & ~read_block.
  - mx_waitrequest = sdram_waitrequest | read_block | ~reqx.
  - The non-owner's waitrequest is held at 1.
- Accepted transfer: sdram_chipselect & ~sdram_waitrequest. Each accepted transfer increments the burst count (saturating at MAX_BURST). An accepted read also pushes tag x into the FIFO.
- Leaving OWNx is evaluated at the clock edge:
  - If ~reqx, or (burst count reaches MAX_BURST and the other master requests): go to OWN(other) if the other master requests, else IDLE.
  - On leaving: last_owner ← x and burst count ← 0.
  - If the other master is not requesting, the burst cap has no effect and the owner keeps the grant.
- read_block = the owner is reading and the FIFO count equals MAX_PENDING. When the FIFO is full, a new read stalls even if a pop occurs in the same cycle. Writes are never blocked by the FIFO.
- Return path:
  - sdram_readdata drives both mN_readdata unconditionally.
  - On sdram_readdatavalid, mN_readdatavalid is asserted only for N equal to the FIFO head tag, in the same cycle (0 added latency), and the head is popped.
  - If the FIFO is empty when readdatavalid arrives: neither master's readdatavalid asserts and err_orphan sets. err_orphan is cleared only by reset.
- Simultaneous push and pop with the FIFO not full: the count is unchanged and tag ordering is preserved. The FIFO pointers wrap modulo MAX_PENDING.
- Writes issued while reads are outstanding are allowed. The controller returns read data in issue order, and the FIFO relies on this.

Test Plan:
- m1 alone issues a write to addr 0x000123 with data 0xBEEF and be_n=00 → IDLE→OWN1 after 1 cycle; sdram_* carries 0x000123/0xBEEF, chipselect=1, write_n=0; m0_waitrequest stays 1 throughout.
- Both masters request from IDLE after reset → m0 granted first (last_owner=1). With both requesting continuously and sdram_waitrequest=0: 8 m0 transfers, then 8 m1 transfers, then m0 again.
- m0 issues 4 reads while the controller holds readdatavalid off → the 5th read stalls (m0_waitrequest=1) until the first readdatavalid; each m0_readdatavalid appears in the same cycle as sdram_readdatavalid.
- Interleaved reads m0, m1, m0 with return data 0x1111, 0x2222, 0x3333 → m0 receives 0x1111 and 0x3333, m1 receives 0x2222; the other master's readdatavalid stays 0 on each beat.
- sdram_readdatavalid pulsed with no reads outstanding → no mN_readdatavalid asserts; err_orphan=1 and stays 1 until reset.
- reset_reset_n asserted low mid-burst with 2 reads pending → all outputs immediately take their reset values; after release, the FIFO is empty and the next readdatavalid sets err_orphan.
